// File: rtl/core_pkg.sv
// Shared TOY-core opcode definitions and operand decode helpers.
// Used by the decoder and by the issue window.
package core_pkg;

    localparam int REG_N = 16;

    typedef enum logic [3:0] {
        OP_HALT = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_SHL  = 4'h6,
        OP_LI   = 4'h7,
        OP_LD   = 4'h8,
        OP_ST   = 4'h9,
        OP_LDX  = 4'hA,
        OP_STX  = 4'hB,
        OP_BEQ  = 4'hC,
        OP_BNE  = 4'hD,
        OP_JR   = 4'hE,
        OP_JAL  = 4'hF
    } op_e;

    function automatic op_e op_of(input logic [15:0] instr);
        return op_e'(instr[15:12]);
    endfunction

    function automatic logic [REG_N-1:0] reg_bit(input logic [3:0] r);
        return REG_N'(1) << r;
    endfunction

    // Fields: op[15:12] rd[11:8] rs[7:4] rt[3:0]
    function automatic logic [REG_N-1:0] src_mask(input logic [15:0] instr);
        logic [REG_N-1:0] m;
        m = '0;
        case (instr[15:12])
            4'h1, 4'h2, 4'h3,
            4'h4, 4'h5, 4'h6: m = reg_bit(instr[7:4]) | reg_bit(instr[3:0]);
            4'h9, 4'hC,
            4'hD, 4'hE:       m = reg_bit(instr[11:8]);
            4'hA:             m = reg_bit(instr[3:0]);
            4'hB:             m = reg_bit(instr[11:8]) | reg_bit(instr[3:0]);
            default:          m = '0;
        endcase
        return m;
    endfunction

    function automatic logic has_dest(input logic [15:0] instr);
        logic d;
        case (instr[15:12])
            4'h1, 4'h2, 4'h3, 4'h4,
            4'h5, 4'h6, 4'h7, 4'h8,
            4'hA, 4'hF: d = 1'b1;
            default:    d = 1'b0;
        endcase
        return d;
    endfunction

    // r0 is never tracked, so it never creates a dependency.
    function automatic logic [REG_N-1:0] dest_mask(input logic [15:0] instr);
        logic [REG_N-1:0] m;
        m = '0;
        if (has_dest(instr) && instr[11:8] != 4'h0)
            m = reg_bit(instr[11:8]);
        return m;
    endfunction

    function automatic logic is_mem(input op_e op);
        return (op >= OP_LD) && (op <= OP_STX);
    endfunction

    function automatic logic is_ctrl(input op_e op);
        return op >= OP_BEQ;
    endfunction

endpackage

// File: rtl/core_scoreboard.sv
// Pending-write scoreboard: one dirty bit per register.
// Set ports win over clear ports; r0 stays clear.
module core_scoreboard
    import core_pkg::*;
#(
    parameter int ISSUE_W  = 2,
    parameter int WB_PORTS = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ISSUE_W-1:0]    set_en_i,
    input  logic [ISSUE_W*4-1:0]  set_rd_i,
    input  logic [WB_PORTS-1:0]   clr_en_i,
    input  logic [WB_PORTS*4-1:0] clr_rd_i,
    output logic [REG_N-1:0]      dirty_o
);

    logic [REG_N-1:0] dirty_q;
    logic [REG_N-1:0] dirty_d;
    logic [REG_N-1:0] set_m;
    logic [REG_N-1:0] clr_m;

    always_comb begin
        set_m = '0;
        clr_m = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            if (set_en_i[k])
                set_m = set_m | reg_bit(set_rd_i[k*4 +: 4]);
        end
        for (int p = 0; p < WB_PORTS; p++) begin
            if (clr_en_i[p])
                clr_m = clr_m | reg_bit(clr_rd_i[p*4 +: 4]);
        end
        dirty_d    = (dirty_q & ~clr_m) | set_m;
        dirty_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) dirty_q <= '0;
        else         dirty_q <= dirty_d;
    end

    assign dirty_o = dirty_q;

endmodule

// File: rtl/core_issue_window.sv
// In-order issue window: circular FIFO of fetched instructions,
// issuing up to ISSUE_W hazard-free instructions per cycle.
module core_issue_window
    import core_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ISSUE_W  = 2,
    parameter int WB_PORTS = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [15:0]           in_instr_i,
    input  logic [7:0]            in_pc_i,
    input  logic                  stall_i,
    input  logic                  lsu_ready_i,
    output logic [ISSUE_W-1:0]    iss_valid_o,
    output logic [ISSUE_W*16-1:0] iss_instr_o,
    output logic [ISSUE_W*8-1:0]  iss_pc_o,
    input  logic                  ctrl_resolve_i,
    input  logic                  ctrl_taken_i,
    input  logic [WB_PORTS-1:0]   wb_en_i,
    input  logic [WB_PORTS*4-1:0] wb_rd_i,
    output logic                  halted_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]        instr_q [DEPTH];
    logic [7:0]         pc_q    [DEPTH];
    logic [AW-1:0]      head_q, head_d;
    logic [AW-1:0]      tail_q, tail_d;
    logic [CW-1:0]      count_q, count_d;
    logic               ctrl_pend_q, ctrl_pend_d;
    logic               halted_q, halted_d;

    logic [REG_N-1:0]   sb_dirty;
    logic [REG_N-1:0]   acc_dest;
    logic [ISSUE_W-1:0] set_en;
    logic [ISSUE_W*4-1:0] set_rd;
    logic [CW-1:0]      n_iss;
    logic [AW-1:0]      idx;
    logic [15:0]        ins;
    op_e                op;
    logic               ok;
    logic               stop;
    logic               ctrl_iss;
    logic               halt_iss;
    logic               flush;
    logic               push;

    core_scoreboard #(
        .ISSUE_W  (ISSUE_W),
        .WB_PORTS (WB_PORTS)
    ) u_sb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .set_en_i (set_en),
        .set_rd_i (set_rd),
        .clr_en_i (wb_en_i),
        .clr_rd_i (wb_rd_i),
        .dirty_o  (sb_dirty)
    );

    // Group formation: walk from head, stop at the first entry that cannot go.
    always_comb begin
        iss_valid_o = '0;
        iss_instr_o = '0;
        iss_pc_o    = '0;
        set_en      = '0;
        set_rd      = '0;
        acc_dest    = '0;
        n_iss       = '0;
        idx         = head_q;
        ins         = '0;
        op          = OP_HALT;
        ok          = 1'b0;
        ctrl_iss    = 1'b0;
        halt_iss    = 1'b0;
        stop        = stall_i || ctrl_pend_q || halted_q;
        for (int k = 0; k < ISSUE_W; k++) begin
            idx = head_q + AW'(k);
            ins = instr_q[idx];
            op  = op_of(ins);
            ok  = !stop && (CW'(k) < count_q) &&
                  ((src_mask(ins) & (sb_dirty | acc_dest)) == '0);
            if (is_mem(op) && !lsu_ready_i)
                ok = 1'b0;
            if (op == OP_HALT && (k != 0 || sb_dirty != '0))
                ok = 1'b0;
            if (ok) begin
                iss_valid_o[k]         = 1'b1;
                iss_instr_o[k*16 +: 16] = ins;
                iss_pc_o[k*8 +: 8]     = pc_q[idx];
                set_en[k]              = has_dest(ins);
                set_rd[k*4 +: 4]       = ins[11:8];
                acc_dest               = acc_dest | dest_mask(ins);
                n_iss                  = n_iss + CW'(1);
                if (is_ctrl(op))     ctrl_iss = 1'b1;
                if (op == OP_HALT)   halt_iss = 1'b1;
                if (is_mem(op) || is_ctrl(op) || op == OP_HALT)
                    stop = 1'b1;
            end else begin
                stop = 1'b1;
            end
        end
    end

    always_comb begin
        flush       = ctrl_resolve_i && ctrl_taken_i && ctrl_pend_q;
        in_ready_o  = (count_q < CW'(DEPTH)) && !halted_q && !flush;
        push        = in_valid_i && in_ready_o;
        head_d      = head_q + AW'(n_iss);
        tail_d      = tail_q + AW'(push);
        count_d     = count_q + CW'(push) - n_iss;
        ctrl_pend_d = ctrl_pend_q;
        halted_d    = halted_q | halt_iss;
        if (ctrl_iss)
            ctrl_pend_d = 1'b1;
        else if (ctrl_resolve_i)
            ctrl_pend_d = 1'b0;
        if (flush) begin
            head_d  = tail_q;
            tail_d  = tail_q;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            ctrl_pend_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            ctrl_pend_q <= ctrl_pend_d;
            halted_q    <= halted_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (push) begin
            instr_q[tail_q] <= in_instr_i;
            pc_q[tail_q]    <= in_pc_i;
        end
    end

    assign halted_o = halted_q;

endmodule

// File: doc/core_issue_window.md
# core_issue_window

Parametrised in-order issue window for the TOY core: buffers up to DEPTH fetched instructions and issues up to ISSUE_W per cycle in program order. It tracks register hazards with a registered scoreboard of pending writes and serialises memory, control and halt instructions. It sits between fetch and the ALU/LSU lanes. It replaces the cascaded per-slot decode chain with a single clocked block.

## Interface
- DEPTH, 4: window entries (power of two, ≥ ISSUE_W)
- ISSUE_W, 2: max instructions issued per cycle (lanes)
- WB_PORTS, 3: writeback ports clearing scoreboard bits
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  fetch offers an instruction
- in_ready_o  out  1  window accepts it this cycle
- in_instr_i  in  16  instruction
- in_pc_i  in  8  its address
- stall_i  in  1  execute back-pressure; no issue this cycle
- lsu_ready_i  in  1  LSU can take a memory op
- iss_valid_o  out  ISSUE_W  lane k issues this cycle (contiguous from lane 0)
- iss_instr_o  out  ISSUE_W×16  issued instruction per lane
- iss_pc_o  out  ISSUE_W×8  issued pc per lane
- ctrl_resolve_i  in  1  pending control instruction resolved (pulse)
- ctrl_taken_i  in  1  qualifies resolve: redirect taken
- wb_en_i  in  WB_PORTS  writeback valid
- wb_rd_i  in  WB_PORTS×4  register written back
- halted_o  out  1  halt retired; sticky until reset

## Operation
- Window is a circular FIFO: head = oldest entry. count = number of valid entries. Push when in_valid_i && in_ready_o. in_ready_o = (count < DEPTH) && !halted_o && !flush. Push is never gated by same-cycle issue.
- Operands (op = instr[15:12]):
  - sources: rs,rt for ops 1–6; rd for ops 9, c, d, e; rt for op a; rd,rt for op b.
  - destination rd: ops 1–8, a, f.
- Group formation: examine entries head..head+ISSUE_W-1 in order. Entry k issues iff:
  - all earlier entries in the group issued;
  - none of its sources is dirty in the scoreboard;
  - none of its sources equals the rd of an earlier entry issued this cycle (rd≠0);
  - the class rules below hold.
  The first entry that fails stops the group.
- Class rules:
  - Memory (8–b) requires lsu_ready_i and is the last entry of its group.
  - Control (c–f) is the last entry of its group and sets ctrl_pending.
  - Halt (0) issues only as lane 0 with an all-clear scoreboard and !ctrl_pending. It then sets halted_o.
- No issue at all while stall_i, ctrl_pending, halted_o, or count=0.
- Scoreboard: 16 bits.
  - Issue of an instruction with a destination sets bit rd, except rd=0, which is never set.
  - wb_en_i[p] clears bit wb_rd_i[p].
  - If the same register is cleared and set in one cycle, set wins.
- ctrl_resolve_i clears ctrl_pending.
  - If ctrl_taken_i is also high, all entries are flushed: count←0, head←tail. This includes any push in the same cycle.
  - A resolve without ctrl_pending set is ignored.
- Issued entries are popped; head advances mod DEPTH by the number issued.

## Timing
- Reset values: count=0, head=tail=0, scoreboard=0, ctrl_pending=0, halted_o=0, iss_valid_o=0, iss_instr_o=0, iss_pc_o=0. in_ready_o=1 once reset is released.
- iss_* are combinational from registered state and stall_i/lsu_ready_i. There is no path from in_valid_i to iss_*.
- An entry pushed at edge t is issuable at cycle t+1 at the earliest.
- A writeback at cycle t unblocks a dependent instruction at t+1. There is no bypass.
- A flush on resolve at edge t means in_ready_o is 0 during cycle t (the flush cycle). Fetch redirects, and pushes resume at t+1.
- Full window (count=DEPTH): in_ready_o=0 even if issue frees slots that cycle.
- Reset asserted mid-operation discards all entries and pending state immediately.

## Structure
- core_pkg holds:
  - the op_e opcode enum (16 values);
  - the functions src_mask(instr) (16-bit one-hot-or), has_dest(instr), is_mem(op), is_ctrl(op);
  - the REG_N=16 constant.
  The decoder and this block share these.
- Sub-module core_scoreboard: 16-bit dirty register with ISSUE_W set ports and WB_PORTS clear ports (set wins), r0 hardwired clear. core_issue_window owns the FIFO and group logic.

## Test plan
- Independent ALU ops: push 1123, 1456 (ISSUE_W=2) → both issue in one cycle; bits r1,r4 set; count back to 0.
- Intra-group RAW: push 1123, 2415 → only lane 0 issues. 2415 issues the cycle after wb_en_i clears r1.
- Memory serialisation: push 8A10, 1123 with lsu_ready_i=0 → nothing issues. With lsu_ready_i=1, only 8A10 issues; 1123 issues next cycle.
- Taken branch: push CA05, 1123, 1456.
  - CA05 issues; no further issue while pending.
  - ctrl_resolve_i=ctrl_taken_i=1 → count=0, in_ready_o=0 that cycle, and 1123 never issues.
- Full/back-pressure: DEPTH=4, stall_i=1, push 5 instructions → in_ready_o drops after the 4th. Release stall_i → in-order issue, ISSUE_W per cycle.
- Halt: push 1123, 0000.
  - 0000 waits until r1 is written back, then issues alone; halted_o=1 and in_ready_o=0.
  - Async reset mid-run → all outputs return to their reset values.
